data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder (memory) end of the processor's data-memory load/store interface.
//  Byte-addressed, big-endian word memory of 2**ADDR_W bytes. Serves one 32-bit
//  load or store per request through a valid/ready handshake with programmable
//  wait states, so the core can later be made multi-cycle. A byte-wide debug port
//  lets benches preload and inspect memory.
// PARAMETERS
//  ADDR_W       5  byte-address width; memory depth = 2**ADDR_W bytes
//  WAIT_CYCLES  2  extra cycles between request accept and memory access (0..15)
//  ALIGN_CHECK  0  1 = a request with req_addr[1:0]!=0 is rejected with resp_err
// PORTS
//  clk          in   1       clock; all state changes on its rising edge
//  rst          in   1       asynchronous, active-high reset
//  req_valid    in   1       initiator presents a request
//  req_ready    out  1       responder can accept a request
//  req_write    in   1       1 = store, 0 = load
//  req_addr     in   ADDR_W  byte address of the word's most-significant byte
//  req_wdata    in   32      store data
//  resp_valid   out  1       response available
//  resp_ready   in   1       initiator accepts the response
//  resp_rdata   out  32      load data; 0 for stores and errors
//  resp_err     out  1       misaligned request rejected (ALIGN_CHECK=1 only)
//  dbg_we       in   1       debug byte write
//  dbg_addr     in   ADDR_W  debug byte address
//  dbg_wbyte    in   8       debug write data
//  dbg_rbyte    out  8       combinational read of mem[dbg_addr]
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait
//    counter=0. Memory contents are NOT reset.
//  - FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE. req_ready=1 only in IDLE.
//  - IDLE: on req_valid&&req_ready latch write/addr/wdata; counter<=WAIT_CYCLES;
//    go WAIT if WAIT_CYCLES>0, else ACCESS.
//  - WAIT: decrement counter; when it reaches 1 (i.e. after WAIT_CYCLES cycles)
//    go ACCESS.
//  - ACCESS (one cycle): store writes mem[a]=wdata[31:24], mem[a+1]=[23:16],
//    mem[a+2]=[15:8], mem[a+3]=[7:0]; load captures the same four bytes into
//    resp_rdata in that order. Byte offsets a+1..a+3 wrap modulo 2**ADDR_W.
//    Then go RESP with resp_valid=1.
//  - Misaligned with ALIGN_CHECK=1: no memory read or write; resp_err=1,
//    resp_rdata=0; timing identical to a normal request.
//  - RESP: hold resp_valid/rdata/err stable until resp_ready; on that edge clear
//    resp_valid, resp_err and go IDLE. Next request acceptable on the following
//    edge (no overlap; one transaction in flight).
//  - Latency: accept edge N -> resp_valid high after edge N+WAIT_CYCLES+1.
//  - Request inputs are ignored outside IDLE; latched copy is used throughout.
//  - Debug write: applied on clk edge when dbg_we=1 in any state. If it targets a
//    byte written by an ACCESS-state store on the same edge, the store wins.
//  - Reset mid-transaction: returns to IDLE at once; a store not yet in ACCESS
//    is never committed; an ACCESS-edge store completed before reset stands.
// TESTING
//  1 WAIT_CYCLES=2: dbg preload bytes 0..3 = 12 34 56 78; load addr 0 ->
//    resp_valid 3 edges after accept, resp_rdata=32'h12345678, resp_err=0.
//  2 Store addr 8 wdata 32'hDEADBEEF, then dbg reads 8..11 -> DE AD BE EF;
//    resp_rdata=0 on store response.
//  3 Wrap: store addr 30 wdata 32'hA1B2C3D4 -> mem[30]=A1,[31]=B2,[0]=C3,[1]=D4;
//    load addr 30 returns 32'hA1B2C3D4.
//  4 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable,
//    req_ready=0, second req_valid ignored; release -> IDLE next edge.
//  5 ALIGN_CHECK=1: store addr 5 -> resp_err=1, rdata=0, memory unchanged.
//  6 Assert rst during WAIT of a store to addr 4 -> req_ready=1,
//    resp_valid=0 immediately; mem[4..7] unchanged. Also dbg_we to addr 12
//    on the same edge as an ACCESS store to addr 12 -> store byte retained.

Source files
------------

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory load/store interface: big-endian byte memory
// serving one 32-bit load/store per valid/ready handshake after WAIT_CYCLES wait states.
module data_mem_responder #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 2,
    parameter bit ALIGN_CHECK = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [7:0]        dbg_wbyte,
    output logic [7:0]        dbg_rbyte
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [3:0]        cnt_r;
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              err_r;
    logic [7:0]        mem_r [DEPTH];

    logic              accept_s;
    logic              misalign_s;
    logic              store_s;
    logic [ADDR_W-1:0] addr1_s;
    logic [ADDR_W-1:0] addr2_s;
    logic [ADDR_W-1:0] addr3_s;

    // Byte offsets wrap naturally modulo the memory size.
    assign addr1_s    = addr_r + ADDR_W'(1);
    assign addr2_s    = addr_r + ADDR_W'(2);
    assign addr3_s    = addr_r + ADDR_W'(3);
    assign accept_s   = req_valid && (state_r == IDLE);
    assign misalign_s = ALIGN_CHECK && (addr_r[1:0] != 2'b00);
    assign store_s    = (state_r == ACCESS) && write_r && !misalign_s;
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;
    assign dbg_rbyte  = mem_r[dbg_addr];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 4'd1) begin
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = WAIT;
                end
            end
            ACCESS: next_state_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_r)
            IDLE:    req_ready  = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 4'd0;
            write_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        write_r <= req_write;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        cnt_r   <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ACCESS: begin
                    if (misalign_s) begin
                        rdata_r <= 32'd0;
                        err_r   <= 1'b1;
                    end else if (write_r) begin
                        rdata_r <= 32'd0;
                        err_r   <= 1'b0;
                    end else begin
                        rdata_r <= {mem_r[addr_r], mem_r[addr1_s], mem_r[addr2_s], mem_r[addr3_s]};
                        err_r   <= 1'b0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        err_r <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= 4'd0;
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    // Memory array; store is assigned last so it beats a same-edge debug write
    always_ff @(posedge clk) begin
        if (dbg_we) begin
            mem_r[dbg_addr] <= dbg_wbyte;
        end
        if (store_s) begin
            mem_r[addr_r]  <= wdata_r[31:24];
            mem_r[addr1_s] <= wdata_r[23:16];
            mem_r[addr2_s] <= wdata_r[15:8];
            mem_r[addr3_s] <= wdata_r[7:0];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance without and one with
// alignment checking, both driven by the same stimulus.
module tb_data_mem_responder;

    localparam int WAIT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] ac_rdata;
        logic        ac_err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [7:0]  dbg_wbyte;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  dbg_rbyte;
    logic        ac_req_ready, ac_resp_valid, ac_resp_err;
    logic [31:0] ac_resp_rdata;
    logic [7:0]  ac_dbg_rbyte;

    exp_t        sb_q[$];
    logic [7:0]  model    [32];
    logic [7:0]  model_ac [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(5), .WAIT_CYCLES(WAIT), .ALIGN_CHECK(1'b0)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wbyte(dbg_wbyte), .dbg_rbyte(dbg_rbyte)
    );

    data_mem_responder #(.ADDR_W(5), .WAIT_CYCLES(WAIT), .ALIGN_CHECK(1'b1)) u_dut_ac (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ac_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(ac_resp_valid), .resp_ready(resp_ready), .resp_rdata(ac_resp_rdata),
        .resp_err(ac_resp_err), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wbyte(dbg_wbyte), .dbg_rbyte(ac_dbg_rbyte)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [4:0] a, input bit ac);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            w[8*(3-k) +: 8] = ac ? model_ac[a + 5'(k)] : model[a + 5'(k)];
        end
        return w;
    endfunction

    task automatic dbg_write(input logic [4:0] a, input logic [7:0] b);
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = a; dbg_wbyte = b;
        @(posedge clk);
        #1 dbg_we = 1'b0;
        model[a] = b;
        model_ac[a] = b;
    endtask

    task automatic dbg_check(input string tag, input logic [4:0] a);
        @(negedge clk);
        dbg_addr = a;
        #1;
        chk(tag, {24'd0, dbg_rbyte}, {24'd0, model[a]});
        chk({tag, "_ac"}, {24'd0, ac_dbg_rbyte}, {24'd0, model_ac[a]});
    endtask

    // One transaction: push expectation, accept, wait response, optional backpressure.
    task automatic txn(input string tag, input bit w, input logic [4:0] a, input logic [31:0] d,
                       input int hold, input bit coll);
        exp_t e;
        exp_t got;
        bit   mis;
        int   guard;
        int   edges;
        mis        = (a[1:0] != 2'b00);
        e.rdata    = w ? 32'd0 : model_word(a, 1'b0);
        e.err      = 1'b0;
        e.ac_rdata = (w || mis) ? 32'd0 : model_word(a, 1'b1);
        e.ac_err   = mis;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
        edges = 0;
        @(negedge clk);
        while (!resp_valid && edges < 20) begin
            if (coll && edges == WAIT) begin
                dbg_we = 1'b1; dbg_addr = a; dbg_wbyte = 8'hFF;
                model[a] = 8'hFF;
                model_ac[a] = 8'hFF;
            end
            @(posedge clk);
            edges++;
            #1 dbg_we = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(edges), 32'(WAIT + 1));
        chk({tag, "_ac_valid"}, {31'd0, ac_resp_valid}, 32'd1);
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            chk({tag, "_rdata"}, resp_rdata, got.rdata);
            chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, got.err});
            chk({tag, "_ac_rdata"}, ac_resp_rdata, got.ac_rdata);
            chk({tag, "_ac_err"}, {31'd0, ac_resp_err}, {31'd0, got.ac_err});
        end else begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd16; req_wdata = 32'h0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
            chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_done_err"}, {31'd0, ac_resp_err}, 32'd0);
        if (w) begin
            for (int k = 0; k < 4; k++) begin
                model[a + 5'(k)] = d[8*(3-k) +: 8];
                if (!mis) model_ac[a + 5'(k)] = d[8*(3-k) +: 8];
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0; req_wdata = 32'd0;
        resp_ready = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wbyte = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        rst = 1'b0;

        dbg_write(5'd0, 8'h12); dbg_write(5'd1, 8'h34);
        dbg_write(5'd2, 8'h56); dbg_write(5'd3, 8'h78);
        txn("load0", 1'b0, 5'd0, 32'h0, 0, 1'b0);
        chk("load0_const", model_word(5'd0, 1'b0), 32'h12345678);

        txn("store8", 1'b1, 5'd8, 32'hDEADBEEF, 0, 1'b0);
        for (int k = 8; k < 12; k++) dbg_check("store8_mem", 5'(k));

        dbg_write(5'd30, 8'h30); dbg_write(5'd31, 8'h31);
        txn("store30", 1'b1, 5'd30, 32'hA1B2C3D4, 0, 1'b0);
        dbg_check("wrap30", 5'd30); dbg_check("wrap31", 5'd31);
        dbg_check("wrap0", 5'd0);   dbg_check("wrap1", 5'd1);
        txn("load30", 1'b0, 5'd30, 32'h0, 0, 1'b0);

        dbg_write(5'd16, 8'h5A);
        txn("bp_load8", 1'b0, 5'd8, 32'h0, 5, 1'b0);
        dbg_check("bp_ignored", 5'd16);

        dbg_write(5'd5, 8'h55); dbg_write(5'd6, 8'h66); dbg_write(5'd7, 8'h77);
        txn("mis_store5", 1'b1, 5'd5, 32'h0BADF00D, 0, 1'b0);
        for (int k = 5; k < 9; k++) dbg_check("mis_mem", 5'(k));
        txn("mis_load1", 1'b0, 5'd1, 32'h0, 0, 1'b0);

        dbg_write(5'd4, 8'h01); dbg_write(5'd5, 8'h02);
        dbg_write(5'd6, 8'h03); dbg_write(5'd7, 8'h04);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd4; req_wdata = 32'hCAFEBABE;
        sb_q.push_back('{32'd0, 1'b0, 32'd0, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mid_ac_ready", {31'd0, ac_req_ready}, 32'd1);
        chk("rst_mid_sb", 32'(sb_q.size()), 32'd1);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        for (int k = 4; k < 8; k++) dbg_check("rst_mem", 5'(k));

        txn("coll_store12", 1'b1, 5'd12, 32'h11223344, 0, 1'b1);
        dbg_check("coll12", 5'd12);
        dbg_check("coll13", 5'd13);
        chk("coll12_const", {24'd0, model[12]}, 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
